// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment code type, hex glyph table and blank constants for the scan driver.
package seven_seg_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam logic DP_OFF = 1'b1;
  // Active-low {g,f,e,d,c,b,a} glyphs for 0-9, A, b, C, d, E, F
  localparam seg_t HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/seven_seg_hex_decode.sv
// seven_seg_hex_decode: combinational hex nibble to active-low seven-segment code.
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = HEX_GLYPH[nib_i];
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed hex display driver with frame-aligned double-buffered data.
// Define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank digits above the most significant non-zero nibble.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [4*NUM_DIGITS-1:0] disp_value,
  input  logic [NUM_DIGITS-1:0]   disp_dp_mask,
  input  logic [NUM_DIGITS-1:0]   disp_en_mask,
  input  logic                    disp_load,
  input  logic                    disp_enable,
  output logic                    disp_pending,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              SEG,
  output logic                    DP
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, act_val_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_en_q, act_dp_q, act_en_q;
  logic                    pend_flag_q, pend_flag_d, frame_done_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d, glyph;
  logic                    dp_q, dp_d;
  logic                    tick, wrap, lit, lead_blank;

  assign tick = presc_q == PW'(REFRESH_DIV - 1);
  assign wrap = tick && idx_q == IW'(NUM_DIGITS - 1);
  assign lit  = disp_enable && act_en_q[idx_q];

  seven_seg_hex_decode u_dec (
    .nib_i (act_val_q[{idx_q, 2'b00} +: 4]),
    .seg_o (glyph)
  );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;
  always_comb begin
    msd = '0;
    for (int k = 1; k < NUM_DIGITS; k++) msd = (act_val_q[4*k +: 4] != 4'h0) ? IW'(k) : msd;
  end
  assign lead_blank = idx_q > msd;
`else
  assign lead_blank = 1'b0;
`endif

  always_comb begin
    presc_d     = tick ? '0 : presc_q + PW'(1);
    idx_d       = wrap ? '0 : tick ? idx_q + IW'(1) : idx_q;
    pend_flag_d = disp_load | (pend_flag_q & ~wrap);
    an_d        = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    seg_d       = (lit && !lead_blank) ? glyph : SEG_BLANK;
    dp_d        = lit ? ~act_dp_q[idx_q] : DP_OFF;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      pend_flag_q  <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      dp_q         <= DP_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_flag_q  <= pend_flag_d;
      frame_done_q <= wrap;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      // Commit reads the pre-edge shadow, so a coincident load stays pending
      if (wrap && pend_flag_q) begin
        act_val_q <= pend_val_q;
        act_dp_q  <= pend_dp_q;
        act_en_q  <= pend_en_q;
      end
      if (disp_load) begin
        pend_val_q <= disp_value;
        pend_dp_q  <= disp_dp_mask;
        pend_en_q  <= disp_en_mask;
      end
    end
  end

  assign disp_pending = pend_flag_q;
  assign frame_done   = frame_done_q;
  assign AN           = an_q;
  assign SEG          = seg_q;
  assign DP           = dp_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: randomized and directed checks against a frame-arithmetic reference model.
module tb_seven_seg_scan_driver;
  localparam int ND = 8, RD = 4, FRAME = ND * RD;
  localparam logic [6:0] GLY [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        ACLK = 1'b0, ARESETN = 1'b0, disp_load = 1'b0, disp_enable = 1'b0;
  logic [31:0] disp_value = '0;
  logic [7:0]  disp_dp_mask = '0, disp_en_mask = '0;
  logic        disp_pending, frame_done, DP;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  int tests = 0, failed = 0, seen_a = 0;

  int          n;
  logic [31:0] pend_val, act_val;
  logic [7:0]  pend_dp, pend_en, act_dp, act_en;
  logic        pflag, exp_fd, exp_dp;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .disp_value(disp_value), .disp_dp_mask(disp_dp_mask),
    .disp_en_mask(disp_en_mask), .disp_load(disp_load), .disp_enable(disp_enable),
    .disp_pending(disp_pending), .frame_done(frame_done), .AN(AN), .SEG(SEG), .DP(DP)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; pflag = 0; pend_val = 0; act_val = 0;
    pend_dp = 0; pend_en = 0; act_dp = 0; act_en = 0;
  endtask

  // Digit shown in cycle n is (n / RD) mod ND; the frame wraps at the last cycle of each FRAME
  task automatic model_edge();
    int idx, top;
    logic wrap, on;
    idx  = (n / RD) % ND;
    wrap = (n % FRAME) == FRAME - 1;
    on   = disp_enable && act_en[idx];
    top  = 0;
    for (int k = ND - 1; k > 0; k--) if (top == 0 && ((act_val >> (4 * k)) & 32'hF) != 0) top = k;
    exp_an  = on ? ~(8'(1) << idx) : 8'hFF;
    exp_seg = on ? GLY[(act_val >> (4 * idx)) & 32'hF] : 7'h7F;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (on && idx > top) exp_seg = 7'h7F;
`endif
    exp_dp = on ? !act_dp[idx] : 1'b1;
    exp_fd = wrap;
    if (wrap && pflag) begin act_val = pend_val; act_dp = pend_dp; act_en = pend_en; end
    pflag = disp_load || (pflag && !wrap);
    if (disp_load) begin pend_val = disp_value; pend_dp = disp_dp_mask; pend_en = disp_en_mask; end
    n++;
  endtask

  task automatic step();
    @(posedge ACLK);
    model_edge();
    @(negedge ACLK);
    chk("AN", AN, exp_an);
    chk("SEG", SEG, exp_seg);
    chk("DP", DP, exp_dp);
    chk("pending", disp_pending, pflag);
    chk("frame_done", frame_done, exp_fd);
    if (SEG == 7'h08) seen_a++;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic load(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dp);
    disp_value = v; disp_en_mask = en; disp_dp_mask = dp; disp_load = 1'b1;
    step();
    disp_load = 1'b0;
  endtask

  task automatic to_phase(input int ph);
    for (int i = 0; i < FRAME && (n % FRAME) != ph; i++) step();
  endtask

  initial begin
    model_reset();
    @(negedge ACLK);
    chk("rst_AN", AN, 8'hFF);
    chk("rst_SEG", SEG, 7'h7F);
    chk("rst_DP", DP, 1'b1);
    chk("rst_pending", disp_pending, 1'b0);
    chk("rst_fd", frame_done, 1'b0);
    disp_enable = 1'b1;
    ARESETN = 1'b1;
    run(70);
    chk("idle_AN", AN, 8'hFF);

    to_phase(5);
    load(32'h12345678, 8'hFF, 8'h01);
    chk("load_pending", disp_pending, 1'b1);
    to_phase(0);
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (exp_an == 8'hFE) begin chk("d0_seg", SEG, 7'h00); chk("d0_dp", DP, 1'b0); end
      if (exp_an == 8'h7F) begin chk("d7_seg", SEG, 7'h79); chk("d7_dp", DP, 1'b1); end
    end

    seen_a = 0;
    to_phase(3);
    load(32'hAAAAAAAA, 8'hFF, 8'h00);
    run(4);
    load(32'h55555555, 8'hFF, 8'h00);
    run(2 * FRAME + 4);
    chk("no_A", seen_a, 0);

    to_phase(8);
    load(32'h11111111, 8'hFF, 8'h0F);
    to_phase(FRAME - 1);
    load(32'h22222222, 8'hFF, 8'hF0);
    chk("wrap_pend_hold", disp_pending, 1'b1);
    run(2 * FRAME + 4);

    to_phase(6);
    load(32'h000000F0, 8'hFF, 8'h00);
    run(2 * FRAME);

    for (int i = 0; i < 600; i++) begin
      disp_value   = $urandom;
      disp_en_mask = 8'($urandom);
      disp_dp_mask = 8'($urandom);
      disp_load    = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 39) == 0) disp_enable = ~disp_enable;
      step();
    end
    disp_load = 1'b0;
    disp_enable = 1'b1;
    load(32'h9ABCDEF0, 8'hFF, 8'hA5);
    run(2 * FRAME);

    to_phase(9);
    load(32'h87654321, 8'hFF, 8'hFF);
    run(3);
    #2 ARESETN = 1'b0;
    #1;
    chk("mid_rst_AN", AN, 8'hFF);
    chk("mid_rst_SEG", SEG, 7'h7F);
    chk("mid_rst_DP", DP, 1'b1);
    chk("mid_rst_pending", disp_pending, 1'b0);
    chk("mid_rst_fd", frame_done, 1'b0);
    model_reset();
    @(negedge ACLK);
    ARESETN = 1'b1;
    run(2 * FRAME);
    chk("post_rst_AN", AN, 8'hFF);
    load(32'h00000000, 8'hFF, 8'h00);
    run(2 * FRAME);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
